// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between the fetch stage
// and the memory (load/store) stage. The data side wins every conflict.
// A grant lasts until mem_ack, or until WAIT_MAX grant cycles elapse, which
// completes the access with read data 0x0000 and sets the sticky err flag.
// Each access ends with a one-cycle RESP state carrying the done pulse.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch read request and address
//   if_rdata/if_done/if_stall    fetch response, done pulse, stall
//   dm_rd/dm_wr/dm_addr/dm_wdata memory stage load/store request
//   dm_rdata/dm_done/dm_stall    load response, done pulse, stall
//   halt                         blocks new fetch grants while high
//   mem_req/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_ack  memory port
//   err                          sticky error (rd+wr together, or timeout)
//   conflict_cnt                 IDLE cycles where fetch lost to data
module mem_port_arbiter #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [15:0]      if_addr,
  output logic [15:0]      if_rdata,
  output logic             if_done,
  output logic             if_stall,
  input  logic             dm_rd,
  input  logic             dm_wr,
  input  logic [15:0]      dm_addr,
  input  logic [15:0]      dm_wdata,
  output logic [15:0]      dm_rdata,
  output logic             dm_done,
  output logic             dm_stall,
  input  logic             halt,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             err,
  output logic [CNT_W-1:0] conflict_cnt
);

  // The wait counter only needs to reach WAIT_MAX-1: the last grant cycle.
  localparam int unsigned WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {IDLE, GNT_D, GNT_I, RESP_D, RESP_I} state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_wr_q, mem_wr_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      if_rdata_q, if_rdata_d;
  logic [15:0]      dm_rdata_q, dm_rdata_d;
  logic             if_done_q, if_done_d;
  logic             dm_done_q, dm_done_d;

  logic             data_req;
  logic             fetch_ok;
  logic             finish;
  logic [15:0]      rdata_next;

  assign data_req = dm_rd | dm_wr;
  assign fetch_ok = if_req & ~halt;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wait_d      = wait_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    finish      = 1'b0;
    rdata_next  = mem_rdata;

    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wait_d      = '0;
          if (dm_rd && dm_wr) err_d = 1'b1;
          if (fetch_ok && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end else if (fetch_ok) begin
          state_d    = GNT_I;
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = if_addr;
          wait_d     = '0;
        end
      end
      GNT_D, GNT_I: begin
        wait_d = wait_q + WW'(1);
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          finish     = 1'b1;
          rdata_next = mem_rdata;
        end else if (wait_q == WAIT_LAST) begin
          finish     = 1'b1;
          rdata_next = '0;
          err_d      = 1'b1;
        end
        if (finish) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          wait_d    = '0;
          if (state_q == GNT_D) begin
            state_d   = RESP_D;
            dm_done_d = 1'b1;
            if (!mem_wr_q) dm_rdata_d = rdata_next;
          end else begin
            state_d    = RESP_I;
            if_done_d  = 1'b1;
            if_rdata_d = rdata_next;
          end
        end
      end
      RESP_D, RESP_I: begin
        state_d = IDLE;
        wait_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign err          = err_q;
  assign conflict_cnt = cnt_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign if_done      = if_done_q;
  assign dm_done      = dm_done_q;
  assign if_stall     = if_req & ~if_done_q;
  assign dm_stall     = data_req & ~dm_done_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 16-bit pipelined processor.
- Grants one requester at a time, holding the other stalled, and registers the returned data.
- Data side wins every conflict, because it is the older instruction.
- Also provides a hung-access timeout, halt gating of fetches, and a conflict counter for the sim log.

Parameters:
- WAIT_MAX, 15: maximum cycles in a grant state without mem_ack before forced completion with error.
- CNT_W, 16: width of conflict_cnt.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- if_req  in  1  fetch requests instruction read; held until if_done
- if_addr  in  16  fetch address (PC)
- if_rdata  out  16  registered instruction, valid when if_done=1, held until next if_done
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  if_req & ~if_done
- dm_rd  in  1  memory stage load request; held until dm_done
- dm_wr  in  1  memory stage store request; held until dm_done
- dm_addr  in  16  load/store address
- dm_wdata  in  16  store data
- dm_rdata  out  16  registered load data, valid when dm_done=1, held until next dm_done
- dm_done  out  1  one-cycle completion pulse to memory stage
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- halt  in  1  Halt decoded; blocks new fetch grants while high
- mem_req  out  1  request to memory, high for the whole grant state
- mem_wr  out  1  write strobe, qualified by mem_req
- mem_addr  out  16  latched address
- mem_wdata  out  16  latched store data
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only in a grant state
- err  out  1  sticky error flag
- conflict_cnt  out  CNT_W  count of IDLE cycles where fetch lost to data

Behaviour:
- States: IDLE, GNT_D, GNT_I, RESP_D, RESP_I.
- Reset (rst=0, asynchronous): state=IDLE; all outputs, latched address/data, wait counter, err and conflict_cnt cleared to 0.
- Reset mid-access: mem_req drops in the same cycle; any pending ack is lost and the requester re-issues.
- IDLE:
  - If dm_rd|dm_wr: latch dm_addr, dm_wdata and mem_wr=dm_wr, then go to GNT_D.
  - Else if if_req & ~halt: latch if_addr with mem_wr=0, then go to GNT_I.
  - Else stay in IDLE.
- dm_rd and dm_wr high together: treated as a write; err set.
- Conflict counting: a cycle in IDLE with data request and if_req & ~halt increments conflict_cnt, which saturates at all-ones.
- GNT_D/GNT_I:
  - mem_req=1 and the latched values drive mem_addr, mem_wr and mem_wdata; the wait counter increments every cycle.
  - On mem_ack: capture mem_rdata (reads only) into dm_rdata or if_rdata, then go to RESP_D or RESP_I.
  - If the counter reaches WAIT_MAX without an ack: set err, load 0x0000 as read data, and go to RESP.
- RESP_D/RESP_I: mem_req=0; dm_done or if_done=1 for exactly this cycle; the wait counter clears; next state is IDLE unconditionally, and requests are not sampled in RESP.
- Latency with a memory acking k cycles after mem_req rises (k>=0, same-cycle ack: k=0):
  - Request seen in IDLE at cycle 0.
  - mem_req is high in cycles 1..1+k.
  - done pulses at cycle 2+k.
  - The earliest next grant starts at cycle 4+k.
- Stores: dm_rdata is unchanged on store completion.
- mem_ack outside a grant state is ignored.
- Halt:
  - An in-flight fetch grant completes normally.
  - A data request is still served while halt=1.
  - if_stall stays asserted while if_req is held.
- err is cleared only by reset.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010, memory acks after 2 cycles with 0xC2A5 -> mem_req high cycles 1–3, if_done pulse cycle 4, if_rdata=0xC2A5, if_stall=1 cycles 0–3.
- Conflict: if_req and dm_rd (addr 0x0200, data 0x1234) raised in the same cycle -> data granted first, dm_rdata=0x1234; fetch granted afterwards; conflict_cnt=1.
- Store: dm_wr=1, dm_addr=0x0040, dm_wdata=0xBEEF, ack=0 cycles -> mem_wr=1 with those values for one cycle; dm_done one cycle later; dm_rdata unchanged.
- Timeout: memory never acks fetch at 0x0002 -> after 15 grant cycles if_done pulses, if_rdata=0x0000, err=1 and remains 1.
- Halt: halt=1 with if_req=1 -> mem_req stays 0 for 20 cycles; a dm_rd in that window is still served.
- Async reset: rst driven low mid-GNT_D -> mem_req, dm_stall bookkeeping, err and conflict_cnt are 0 before the next clk edge; after release, state is IDLE.
